// File: rtl/cofre_param.sv
// Digital safe with a BCD keypad: N_DIGITS-digit password, retry counter with timed lockout,
// and in-place password change while open.
module cofre_param #(
    parameter int unsigned              N_DIGITS  = 4,
    parameter logic [N_DIGITS*4-1:0]    SENHA_INI = 16'h3015,
    parameter int unsigned              MAX_TENT  = 3,
    parameter int unsigned              T_ERRO    = 150_000_000,
    parameter int unsigned              T_BLOQ    = 500_000_000
) (
    input  logic                    MAX10_CLK1_50,
    input  logic                    RST,
    input  logic [3:0]              digito,
    input  logic                    confirma,
    input  logic                    troca,
    input  logic                    fecha,
    output logic [2:0]              estado,
    output logic                    aberto,
    output logic                    erro,
    output logic                    bloqueado,
    output logic [N_DIGITS*4-1:0]   digitos_vis,
    output logic [2:0]              n_entrados,
    output logic [3:0]              tentativas,
    output logic [31:0]             resto_bloq
);

    localparam int unsigned W = N_DIGITS * 4;

    localparam logic [2:0] StInicio    = 3'd0;
    localparam logic [2:0] StEntrada   = 3'd1;
    localparam logic [2:0] StVerifica  = 3'd2;
    localparam logic [2:0] StAberto    = 3'd3;
    localparam logic [2:0] StNovaSenha = 3'd4;
    localparam logic [2:0] StErro      = 3'd5;
    localparam logic [2:0] StBloqueado = 3'd6;

    localparam logic [W-1:0] Vazio   = {W{1'b1}};
    localparam logic [2:0]   LastPos = 3'(N_DIGITS - 1);
    localparam logic [3:0]   TentLim = 4'(MAX_TENT - 1);

    logic [2:0]   state_q, state_d;
    logic [W-1:0] senha_q, senha_d;
    logic [W-1:0] digitos_q, digitos_d;
    logic [W-1:0] digitos_ins;
    logic [2:0]   n_q, n_d;
    logic [3:0]   tent_q, tent_d;
    logic [31:0]  resto_q, resto_d;
    logic [31:0]  timer_q, timer_d;
    logic         confirma_q;
    logic         press;
    logic         valid;

    assign press = confirma & ~confirma_q;
    assign valid = (digito <= 4'd9);

    always_comb begin
        // Position 0 (first entered) lives in the most significant nibble.
        digitos_ins = digitos_q;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (n_q == 3'(i)) begin
                digitos_ins[(int'(N_DIGITS) - 1 - i) * 4 +: 4] = digito;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        senha_d   = senha_q;
        digitos_d = digitos_q;
        n_d       = n_q;
        tent_d    = tent_q;
        resto_d   = resto_q;
        timer_d   = timer_q;

        case (state_q)
            StInicio, StEntrada: begin
                if (press && valid) begin
                    digitos_d = digitos_ins;
                    n_d       = n_q + 3'd1;
                    state_d   = (n_q == LastPos) ? StVerifica : StEntrada;
                end
            end
            StVerifica: begin
                if (digitos_q == senha_q) begin
                    tent_d  = 4'd0;
                    state_d = StAberto;
                end else if (tent_q < TentLim) begin
                    tent_d  = tent_q + 4'd1;
                    timer_d = 32'(T_ERRO - 1);
                    state_d = StErro;
                end else begin
                    resto_d = 32'(T_BLOQ);
                    state_d = StBloqueado;
                end
            end
            StAberto: begin
                if (fecha) begin
                    state_d   = StInicio;
                    digitos_d = Vazio;
                    n_d       = 3'd0;
                end else if (troca) begin
                    state_d   = StNovaSenha;
                    digitos_d = Vazio;
                    n_d       = 3'd0;
                end
            end
            StNovaSenha: begin
                if (press && valid) begin
                    digitos_d = digitos_ins;
                    n_d       = n_q + 3'd1;
                    if (n_q == LastPos) begin
                        senha_d = digitos_ins;
                        state_d = StAberto;
                    end
                end
            end
            StErro: begin
                if (timer_q == 32'd0) begin
                    state_d   = StInicio;
                    digitos_d = Vazio;
                    n_d       = 3'd0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            StBloqueado: begin
                if (resto_q <= 32'd1) begin
                    state_d   = StInicio;
                    digitos_d = Vazio;
                    n_d       = 3'd0;
                    tent_d    = 4'd0;
                    resto_d   = 32'd0;
                end else begin
                    resto_d = resto_q - 32'd1;
                end
            end
            default: begin
                state_d   = StInicio;
                digitos_d = Vazio;
                n_d       = 3'd0;
            end
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (RST) begin
            state_q    <= StInicio;
            senha_q    <= SENHA_INI;
            digitos_q  <= Vazio;
            n_q        <= 3'd0;
            tent_q     <= 4'd0;
            resto_q    <= 32'd0;
            timer_q    <= 32'd0;
            confirma_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            senha_q    <= senha_d;
            digitos_q  <= digitos_d;
            n_q        <= n_d;
            tent_q     <= tent_d;
            resto_q    <= resto_d;
            timer_q    <= timer_d;
            confirma_q <= confirma;
        end
    end

    assign estado      = state_q;
    assign aberto      = (state_q == StAberto);
    assign erro        = (state_q == StErro);
    assign bloqueado   = (state_q == StBloqueado);
    assign digitos_vis = digitos_q;
    assign n_entrados  = n_q;
    assign tentativas  = tent_q;
    assign resto_bloq  = resto_q;

endmodule

// File: tb/tb_cofre_param.sv
// Directed bench for cofre_param with short ERRO/BLOQUEADO dwell times.
module tb_cofre_param;

    logic        clk;
    logic        rst;
    logic [3:0]  digito;
    logic        confirma;
    logic        troca;
    logic        fecha;
    logic [2:0]  estado;
    logic        aberto;
    logic        erro;
    logic        bloqueado;
    logic [15:0] digitos_vis;
    logic [2:0]  n_entrados;
    logic [3:0]  tentativas;
    logic [31:0] resto_bloq;

    int checks = 0;
    int errors = 0;

    cofre_param #(
        .N_DIGITS  (4),
        .SENHA_INI (16'h3015),
        .MAX_TENT  (3),
        .T_ERRO    (4),
        .T_BLOQ    (10)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RST           (rst),
        .digito        (digito),
        .confirma      (confirma),
        .troca         (troca),
        .fecha         (fecha),
        .estado        (estado),
        .aberto        (aberto),
        .erro          (erro),
        .bloqueado     (bloqueado),
        .digitos_vis   (digitos_vis),
        .n_entrados    (n_entrados),
        .tentativas    (tentativas),
        .resto_bloq    (resto_bloq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] code;
        logic [2:0]  st;
        logic [3:0]  tent;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One confirma rising edge; returns with confirma low, effect already registered.
    task automatic press(input logic [3:0] d);
        digito   = d;
        confirma = 1'b1;
        tick();
        confirma = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        press(code[15:12]);
        tick();
        press(code[11:8]);
        tick();
        press(code[7:4]);
        tick();
        press(code[3:0]);
    endtask

    task automatic wait_erro();
        for (int k = 0; k < 4; k++) begin
            chk("erro_dwell", {31'd0, erro}, 32'd1);
            tick();
        end
        chk("erro_exit_state", {29'd0, estado}, 32'd0);
        chk("erro_exit_vis", {16'd0, digitos_vis}, 32'h0000FFFF);
        chk("erro_exit_n", {29'd0, n_entrados}, 32'd0);
    endtask

    task automatic wait_bloq();
        for (int k = 0; k < 10; k++) begin
            chk("bloq_flag", {31'd0, bloqueado}, 32'd1);
            chk("bloq_resto", resto_bloq, 32'(10 - k));
            tick();
        end
        chk("bloq_exit_state", {29'd0, estado}, 32'd0);
        chk("bloq_exit_tent", {28'd0, tentativas}, 32'd0);
        chk("bloq_exit_resto", resto_bloq, 32'd0);
    endtask

    task automatic open_ok(input logic [15:0] code);
        enter_code(code);
        chk("open_verifica", {29'd0, estado}, 32'd2);
        tick();
        chk("open_aberto", {31'd0, aberto}, 32'd1);
        chk("open_tent", {28'd0, tentativas}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{code: 16'h3015, st: 3'd3, tent: 4'd0};
        tbl[1] = '{code: 16'h1111, st: 3'd5, tent: 4'd1};
        tbl[2] = '{code: 16'h3015, st: 3'd3, tent: 4'd0};
        tbl[3] = '{code: 16'h1111, st: 3'd5, tent: 4'd1};
        tbl[4] = '{code: 16'h3016, st: 3'd5, tent: 4'd2};
        tbl[5] = '{code: 16'h0000, st: 3'd6, tent: 4'd0};
        tbl[6] = '{code: 16'h3015, st: 3'd3, tent: 4'd0};

        rst = 1'b1; digito = 4'd0; confirma = 1'b0; troca = 1'b0; fecha = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_state", {29'd0, estado}, 32'd0);
        chk("rst_vis", {16'd0, digitos_vis}, 32'h0000FFFF);
        chk("rst_n", {29'd0, n_entrados}, 32'd0);
        chk("rst_tent", {28'd0, tentativas}, 32'd0);
        chk("rst_resto", resto_bloq, 32'd0);
        chk("rst_flags", {29'd0, aberto, erro, bloqueado}, 32'd0);

        // Table of full-code attempts, each returned to INICIO afterwards.
        for (int i = 0; i < 7; i++) begin
            enter_code(tbl[i].code);
            chk("tbl_verifica", {29'd0, estado}, 32'd2);
            tick();
            chk("tbl_state", {29'd0, estado}, {29'd0, tbl[i].st});
            chk("tbl_aberto", {31'd0, aberto}, {31'd0, tbl[i].st == 3'd3});
            chk("tbl_erro", {31'd0, erro}, {31'd0, tbl[i].st == 3'd5});
            chk("tbl_bloq", {31'd0, bloqueado}, {31'd0, tbl[i].st == 3'd6});
            chk("tbl_vis", {16'd0, digitos_vis}, {16'd0, tbl[i].code});
            if (tbl[i].st != 3'd6) chk("tbl_tent", {28'd0, tentativas}, {28'd0, tbl[i].tent});
            case (tbl[i].st)
                3'd3: begin
                    fecha = 1'b1;
                    tick();
                    fecha = 1'b0;
                    chk("fecha_state", {29'd0, estado}, 32'd0);
                    chk("fecha_vis", {16'd0, digitos_vis}, 32'h0000FFFF);
                end
                3'd5: wait_erro();
                default: wait_bloq();
            endcase
        end

        // Password change to 9876, old code rejected, new code accepted.
        open_ok(16'h3015);
        troca = 1'b1;
        tick();
        troca = 1'b0;
        chk("troca_state", {29'd0, estado}, 32'd4);
        chk("troca_vis", {16'd0, digitos_vis}, 32'h0000FFFF);
        chk("troca_n", {29'd0, n_entrados}, 32'd0);
        enter_code(16'h9876);
        chk("commit_state", {29'd0, estado}, 32'd3);
        chk("commit_vis", {16'd0, digitos_vis}, 32'h00009876);
        tick();
        fecha = 1'b1;
        tick();
        fecha = 1'b0;
        enter_code(16'h3015);
        tick();
        chk("old_pw_erro", {29'd0, estado}, 32'd5);
        chk("old_pw_tent", {28'd0, tentativas}, 32'd1);
        wait_erro();
        open_ok(16'h9876);

        // Back to SENHA_INI via reset; invalid digits and held confirma.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        press(4'd15);
        chk("inv_inicio_state", {29'd0, estado}, 32'd0);
        chk("inv_inicio_n", {29'd0, n_entrados}, 32'd0);
        tick();
        press(4'd3);
        chk("first_digit_state", {29'd0, estado}, 32'd1);
        chk("first_digit_n", {29'd0, n_entrados}, 32'd1);
        tick();
        press(4'd12);
        chk("inv_entrada_n", {29'd0, n_entrados}, 32'd1);
        chk("inv_entrada_vis", {16'd0, digitos_vis}, 32'h00003FFF);
        tick();
        digito   = 4'd0;
        confirma = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        confirma = 1'b0;
        chk("held_n", {29'd0, n_entrados}, 32'd2);
        chk("held_vis", {16'd0, digitos_vis}, 32'h000030FF);
        tick();
        press(4'd1);
        tick();
        press(4'd5);
        chk("held_verifica", {29'd0, estado}, 32'd2);
        tick();
        chk("held_aberto", {31'd0, aberto}, 32'd1);

        // fecha beats troca.
        fecha = 1'b1;
        troca = 1'b1;
        tick();
        fecha = 1'b0;
        troca = 1'b0;
        chk("fecha_troca_state", {29'd0, estado}, 32'd0);
        tick();
        open_ok(16'h3015);

        // Reset in the middle of a password change.
        troca = 1'b1;
        tick();
        troca = 1'b0;
        press(4'd9);
        tick();
        press(4'd8);
        chk("partial_state", {29'd0, estado}, 32'd4);
        chk("partial_n", {29'd0, n_entrados}, 32'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midnova_rst_state", {29'd0, estado}, 32'd0);
        chk("midnova_rst_vis", {16'd0, digitos_vis}, 32'h0000FFFF);
        open_ok(16'h3015);

        // Reset in the middle of ERRO.
        fecha = 1'b1;
        tick();
        fecha = 1'b0;
        enter_code(16'h1111);
        tick();
        tick();
        chk("miderro_state", {29'd0, estado}, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("miderro_rst_state", {29'd0, estado}, 32'd0);
        chk("miderro_rst_tent", {28'd0, tentativas}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cofre_param.md
COFRE_PARAM -- requirements
Module: cofre_param

Interface
REQ-001 Parameter N_DIGITS, default 4: password length in BCD digits, legal range 1..6.
REQ-002 Parameter SENHA_INI, default 16'h3015: reset password, N_DIGITS*4 bits, first-entered digit in the most significant nibble.
REQ-003 Parameter MAX_TENT, default 3: consecutive wrong entries that trigger lockout, legal range 1..15.
REQ-004 Parameter T_ERRO, default 150_000_000: ERRO dwell in clock cycles, minimum 1.
REQ-005 Parameter T_BLOQ, default 500_000_000: BLOQUEADO dwell in clock cycles, minimum 1.
REQ-006 MAX10_CLK1_50  in  1  system clock; all state changes on its rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 digito  in  4  BCD digit to enter; values 10..15 are invalid.
REQ-009 confirma  in  1  level input, active-high, rising edge detected internally.
REQ-010 troca  in  1  level, request password change; honoured only in ABERTO.
REQ-011 fecha  in  1  level, relock request; honoured only in ABERTO.
REQ-012 estado  out  3  current state code.
REQ-013 aberto / erro / bloqueado  out  1 each  high exactly while in ABERTO / ERRO / BLOQUEADO.
REQ-014 digitos_vis  out  N_DIGITS*4  entered digits, 4'hF in unentered positions.
REQ-015 n_entrados  out  3  count of digits entered in the current sequence.
REQ-016 tentativas  out  4  consecutive wrong-entry count.
REQ-017 resto_bloq  out  32  cycles remaining in BLOQUEADO, 0 otherwise.

Function
REQ-018 State codes: INICIO=0, ENTRADA=1, VERIFICA=2, ABERTO=3, NOVA_SENHA=4, ERRO=5, BLOQUEADO=6; codes 7 go to INICIO on the next cycle.
REQ-019 Press pulse = confirma AND NOT confirma_q, with confirma_q a 1-cycle register; a held level yields one pulse only.
REQ-020 INICIO: a pulse with a valid digito stores that digit at position 0, sets n_entrados=1 and moves to ENTRADA; if N_DIGITS=1 it moves to VERIFICA instead.
REQ-021 ENTRADA: each pulse with a valid digito stores it at position n_entrados and increments n_entrados; on the N_DIGITS-th digit the state moves to VERIFICA.
REQ-022 A pulse with an invalid digito (>9) in INICIO, ENTRADA or NOVA_SENHA is ignored; it changes no register.
REQ-023 VERIFICA lasts exactly 1 cycle and compares all N_DIGITS digits against the stored password.
REQ-024 Match: tentativas<=0 and the state moves to ABERTO.
REQ-025 Mismatch with tentativas+1 < MAX_TENT: tentativas increments and the state moves to ERRO.
REQ-026 Mismatch with tentativas+1 = MAX_TENT: the state moves to BLOQUEADO, with resto_bloq loaded to T_BLOQ.
REQ-027 ERRO lasts exactly T_ERRO cycles, then moves to INICIO.
REQ-028 BLOQUEADO: resto_bloq decrements by 1 each cycle; in the cycle it reads 1 the state moves to INICIO and tentativas<=0.
REQ-029 Pulses are ignored in VERIFICA, ERRO and BLOQUEADO.
REQ-030 Entering INICIO from any state clears digitos_vis to all 4'hF and n_entrados to 0.
REQ-031 ABERTO: fecha moves to INICIO; otherwise troca moves to NOVA_SENHA, clearing digitos_vis and n_entrados.
REQ-032 ABERTO: when fecha and troca are asserted in the same cycle, fecha wins.
REQ-033 NOVA_SENHA collects N_DIGITS valid digits the same way as ENTRADA.
REQ-034 NOVA_SENHA: after the last digit the password register is replaced in one cycle and the state returns to ABERTO; a partial sequence never alters the password.
REQ-035 The password register is writable only at the commit in NOVA_SENHA (REQ-034) and at RST.

Reset
REQ-036 RST high at a rising edge: state INICIO, password<=SENHA_INI, tentativas=0, n_entrados=0, digitos_vis all 4'hF, resto_bloq=0, all timers 0, confirma_q=0.
REQ-037 RST dominates every other input in every state, including mid-entry, mid-ERRO, mid-BLOQUEADO and mid-password-change.

Verification (N_DIGITS=4, SENHA_INI=16'h3015, MAX_TENT=3, T_ERRO=4, T_BLOQ=10)
REQ-038 Pulses with digito 3,0,1,5 -> VERIFICA for 1 cycle, then aberto=1, tentativas=0, digitos_vis=16'h3015.
REQ-039 Three entries of 1,1,1,1 -> first two: erro=1 for exactly 4 cycles, tentativas 1 then 2; third: bloqueado=1, resto_bloq 10..1, INICIO after 10 cycles, tentativas=0.
REQ-040 In ABERTO: troca, then 9,8,7,6, fecha; enter 3,0,1,5 -> ERRO; then enter 9,8,7,6 -> ABERTO.
REQ-041 digito=12 pulse in ENTRADA -> n_entrados unchanged; confirma held high 20 cycles -> exactly one digit stored.
REQ-042 RST during NOVA_SENHA after 2 digits -> INICIO; password 3,0,1,5 opens the safe.
REQ-043 fecha and troca together in ABERTO -> INICIO; password unchanged.
